// File: rtl/ghostbus_host_pkg.sv
// Shared state encodings and constants for the ghostbus host master.
package ghostbus_host_pkg;

  typedef logic [1:0] gb_state_t;

  localparam gb_state_t ST_IDLE  = 2'd0;
  localparam gb_state_t ST_ISSUE = 2'd1;
  localparam gb_state_t ST_WAIT  = 2'd2;
  localparam gb_state_t ST_RESP  = 2'd3;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 8;

  // Data returned on write acknowledgements.
  localparam logic [63:0] RSP_ZERO = '0;

endpackage

// File: rtl/gb_rd_lat_pipe.sv
// Read-strobe delay line: sample_en_o pulses DEPTH cycles after strobe_i.
module gb_rd_lat_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic sample_en_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= DEPTH'({pipe_q, strobe_i});
    end
  end

  assign sample_en_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ghostbus_host_master.sv
// Ghostbus initiator: command stream in, single-cycle bus strobes out, one response per beat.
// Define GHOSTBUS_HOST_BURST_EN to honour cmd_len (multi-beat incrementing bursts).
module ghostbus_host_master
  import ghostbus_host_pkg::*;
#(
  parameter int unsigned AW     = 24,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned LW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [LW-1:0] cmd_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_din,
  output logic          busy
);

  localparam int unsigned LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  gb_state_t     state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] base_q, base_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] beat_q, beat_d;
  logic [AW-1:0] gb_addr_q, gb_addr_d;
  logic [DW-1:0] gb_dout_q, gb_dout_d;
  logic          gb_we_q, gb_we_d;
  logic          gb_re_q, gb_re_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_last_q, rsp_last_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;

  logic          rd_sample_en;
  logic          last_beat_c;
  logic [LW-1:0] next_beat_c;
  logic [LW-1:0] cmd_len_c;

  // Single-beat build captures a zero length, so every beat is the last one.
`ifdef GHOSTBUS_HOST_BURST_EN
  assign cmd_len_c = cmd_len;
`else
  logic cmd_len_unused;
  assign cmd_len_unused = ^cmd_len;
  assign cmd_len_c      = LW'(0);
`endif

  assign last_beat_c = (beat_q == len_q);
  assign next_beat_c = beat_q + LW'(1);

  gb_rd_lat_pipe #(.DEPTH(LAT)) u_rd_lat_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .strobe_i    (gb_re_q),
    .sample_en_o (rd_sample_en)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      gb_addr_q   <= '0;
      gb_dout_q   <= '0;
      gb_we_q     <= 1'b0;
      gb_re_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      gb_addr_q   <= gb_addr_d;
      gb_dout_q   <= gb_dout_d;
      gb_we_q     <= gb_we_d;
      gb_re_q     <= gb_re_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Strobes are registered on entry to ISSUE, so they are visible for exactly that cycle.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    beat_d      = beat_q;
    gb_addr_d   = gb_addr_q;
    gb_dout_d   = gb_dout_q;
    gb_we_d     = 1'b0;
    gb_re_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          we_d      = cmd_we;
          base_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          len_d     = cmd_len_c;
          beat_d    = '0;
          gb_addr_d = cmd_addr;
          gb_we_d   = cmd_we;
          gb_re_d   = !cmd_we;
          if (cmd_we) gb_dout_d = cmd_wdata;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = DW'(RSP_ZERO);
          rsp_last_d  = last_beat_c;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rd_sample_en) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = gb_din;
          rsp_last_d  = last_beat_c;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (last_beat_c) begin
            state_d = ST_IDLE;
          end else begin
            beat_d    = next_beat_c;
            gb_addr_d = base_q + AW'(next_beat_c);
            gb_we_d   = we_q;
            gb_re_d   = !we_q;
            if (we_q) gb_dout_d = wdata_q;
            state_d   = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign gb_addr   = gb_addr_q;
  assign gb_dout   = gb_dout_q;
  assign gb_we     = gb_we_q;
  assign gb_re     = gb_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ghostbus_host_master.sv
// Scoreboard bench for ghostbus_host_master: two instances (RD_LAT 1 and 3) share one command stream.
module tb_ghostbus_host_master;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [31:0] dout;
    logic        first;
  } strb_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_valid, b_valid, cmd_we, rsp_ready;
  logic [23:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [7:0]  cmd_len;

  logic        a_cmd_ready, a_rsp_valid, a_rsp_last, a_gb_we, a_gb_re, a_busy;
  logic [31:0] a_rsp_data, a_gb_dout, a_gb_din;
  logic [23:0] a_gb_addr;
  logic        b_cmd_ready, b_rsp_valid, b_rsp_last, b_gb_we, b_gb_re, b_busy;
  logic [31:0] b_rsp_data, b_gb_dout, b_gb_din;
  logic [23:0] b_gb_addr;

  ghostbus_host_master #(.AW(24), .DW(32), .RD_LAT(1), .LW(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(a_valid), .cmd_ready(a_cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data), .rsp_last(a_rsp_last),
    .gb_addr(a_gb_addr), .gb_dout(a_gb_dout), .gb_we(a_gb_we), .gb_re(a_gb_re),
    .gb_din(a_gb_din), .busy(a_busy)
  );

  ghostbus_host_master #(.AW(24), .DW(32), .RD_LAT(3), .LW(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data), .rsp_last(b_rsp_last),
    .gb_addr(b_gb_addr), .gb_dout(b_gb_dout), .gb_we(b_gb_we), .gb_re(b_gb_re),
    .gb_din(b_gb_din), .busy(b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus responders: 32b reg at 0x000, 64x8 RAM at 0x100; data valid only in the RD_LAT-th cycle.
  logic [31:0] bm_reg [2];
  logic [7:0]  bm_ram [2][64];
  logic        bm_init = 1'b0;
  logic [31:0] b_pipe [3];

  function automatic logic [31:0] bm_rd(input int id, input logic [23:0] a);
    if (a == 24'h0) return bm_reg[id];
    if (a >= 24'h100 && a < 24'h140) return {24'h0, bm_ram[id][a - 24'h100]};
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!bm_init) begin
      for (int i = 0; i < 2; i++) begin
        bm_reg[i] <= 32'h0;
        for (int j = 0; j < 64; j++) bm_ram[i][j] <= 8'(8'h81 + j);
      end
      bm_init <= 1'b1;
    end else begin
      if (a_gb_we && a_gb_addr == 24'h0) bm_reg[0] <= a_gb_dout;
      if (a_gb_we && a_gb_addr >= 24'h100 && a_gb_addr < 24'h140) bm_ram[0][a_gb_addr - 24'h100] <= a_gb_dout[7:0];
      if (b_gb_we && b_gb_addr == 24'h0) bm_reg[1] <= b_gb_dout;
      if (b_gb_we && b_gb_addr >= 24'h100 && b_gb_addr < 24'h140) bm_ram[1][b_gb_addr - 24'h100] <= b_gb_dout[7:0];
    end
    a_gb_din  <= a_gb_re ? bm_rd(0, a_gb_addr) : 32'hBAD0BAD0;
    b_pipe[0] <= b_gb_re ? bm_rd(1, b_gb_addr) : 32'hBAD0BAD0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_gb_din = b_pipe[2];

  // Reference contents used to predict read data when a command is issued.
  logic [31:0] ref_reg;
  logic [7:0]  ref_ram [64];

  function automatic logic [31:0] ref_rd(input logic [23:0] a);
    if (a == 24'h0) return ref_reg;
    if (a >= 24'h100 && a < 24'h140) return {24'h0, ref_ram[a - 24'h100]};
    return 32'h0;
  endfunction

  strb_t st_q [2][$];
  rsp_t  rs_q [2][$];

  logic        prev_strobe [2];
  logic        prev_rv     [2];
  logic        prev_ack    [2];
  logic [31:0] prev_rd     [2];
  logic        prev_rl     [2];
  int          hs_cyc      [2];
  int          strb_cyc    [2];
  int          lat_exp     [2];

  function automatic int rd_lat(input int id);
    return (id == 0) ? 1 : 3;
  endfunction

  task automatic mon_step(input int id, input logic cv, input logic cr, input logic we,
                          input logic re, input logic [23:0] addr, input logic [31:0] dout,
                          input logic rv, input logic [31:0] rd, input logic rl, input logic bsy);
    strb_t s;
    rsp_t  r;
    if (cv && cr) hs_cyc[id] = cyc;
    if (we || re) begin
      check_eq($sformatf("i%0d.we_re_excl", id), 64'(we & re), 0);
      check_eq($sformatf("i%0d.strobe_1cyc", id), 64'(prev_strobe[id]), 0);
      if (st_q[id].size() == 0) begin
        check_eq($sformatf("i%0d.strobe_unexp", id), 64'(st_q[id].size()), 1);
      end else begin
        s = st_q[id].pop_front();
        check_eq($sformatf("i%0d.strb_we", id), 64'(we), 64'(s.we));
        check_eq($sformatf("i%0d.strb_re", id), 64'(re), 64'(!s.we));
        check_eq($sformatf("i%0d.strb_addr", id), 64'(addr), 64'(s.addr));
        if (s.we) check_eq($sformatf("i%0d.strb_dout", id), 64'(dout), 64'(s.dout));
        if (s.first) check_eq($sformatf("i%0d.cmd_to_strb", id), 64'(cyc - hs_cyc[id]), 1);
        strb_cyc[id] = cyc;
        lat_exp[id]  = s.we ? 1 : rd_lat(id) + 1;
      end
    end
    if (rv && !prev_rv[id])
      check_eq($sformatf("i%0d.rsp_latency", id), 64'(cyc - strb_cyc[id]), 64'(lat_exp[id]));
    if (rv) check_eq($sformatf("i%0d.busy_in_rsp", id), 64'(bsy), 1);
    if (rv && prev_rv[id] && !prev_ack[id]) begin
      check_eq($sformatf("i%0d.stall_data", id), 64'(rd), 64'(prev_rd[id]));
      check_eq($sformatf("i%0d.stall_last", id), 64'(rl), 64'(prev_rl[id]));
    end
    if (rv && !rsp_ready) begin
      check_eq($sformatf("i%0d.stall_strobe", id), 64'({we, re}), 0);
      check_eq($sformatf("i%0d.stall_cmd_ready", id), 64'(cr), 0);
    end
    if (rv && rsp_ready) begin
      if (rs_q[id].size() == 0) begin
        check_eq($sformatf("i%0d.rsp_unexp", id), 64'(rs_q[id].size()), 1);
      end else begin
        r = rs_q[id].pop_front();
        check_eq($sformatf("i%0d.rsp_data", id), 64'(rd), 64'(r.data));
        check_eq($sformatf("i%0d.rsp_last", id), 64'(rl), 64'(r.last));
      end
    end
    prev_strobe[id] = we || re;
    prev_rv[id]     = rv;
    prev_ack[id]    = rv && rsp_ready;
    prev_rd[id]     = rd;
    prev_rl[id]     = rl;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_step(0, a_valid, a_cmd_ready, a_gb_we, a_gb_re, a_gb_addr, a_gb_dout,
               a_rsp_valid, a_rsp_data, a_rsp_last, a_busy);
      mon_step(1, b_valid, b_cmd_ready, b_gb_we, b_gb_re, b_gb_addr, b_gb_dout,
               b_rsp_valid, b_rsp_data, b_rsp_last, b_busy);
    end else begin
      for (int i = 0; i < 2; i++) begin
        prev_strobe[i] = 1'b0;
        prev_rv[i]     = 1'b0;
        prev_ack[i]    = 1'b0;
      end
    end
  end

  // Push expectations for every beat, then offer the command to both instances.
  task automatic issue(input logic we, input logic [23:0] addr, input logic [31:0] wdata,
                       input int len);
    int          nb;
    logic [23:0] a;
    logic        ta, tb;
    int          t;
`ifdef GHOSTBUS_HOST_BURST_EN
    nb = len + 1;
`else
    nb = 1;
`endif
    for (int i = 0; i < nb; i++) begin
      a = addr + 24'(i);
      for (int id = 0; id < 2; id++) begin
        st_q[id].push_back('{we: we, addr: a, dout: wdata, first: (i == 0)});
        rs_q[id].push_back('{data: (we ? 32'h0 : ref_rd(a)), last: (i == nb - 1)});
      end
      if (we && a == 24'h0) ref_reg = wdata;
      if (we && a >= 24'h100 && a < 24'h140) ref_ram[a - 24'h100] = wdata[7:0];
    end
    @(posedge clk); #1;
    cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_len = 8'(len);
    a_valid = 1'b1; b_valid = 1'b1;
    t = 0;
    while ((a_valid || b_valid) && t < 100) begin
      ta = a_valid && a_cmd_ready;
      tb = b_valid && b_cmd_ready;
      @(posedge clk); #1;
      if (ta) a_valid = 1'b0;
      if (tb) b_valid = 1'b0;
      t++;
    end
    if (a_valid || b_valid) check_eq("cmd_accept_timeout", 64'({a_valid, b_valid}), 0);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(posedge clk); #1;
      done = (st_q[0].size() == 0) && (st_q[1].size() == 0) && (rs_q[0].size() == 0) &&
             (rs_q[1].size() == 0) && a_cmd_ready && b_cmd_ready;
    end
    check_eq("cmd_complete", 64'(done), 1);
  endtask

  task automatic check_rst(input string tag, input logic cr, input logic rv, input logic rl,
                           input logic we, input logic re, input logic bsy,
                           input logic [23:0] ad, input logic [31:0] dout, input logic [31:0] rd);
    check_eq({tag, ".ctl"}, 64'({cr, rv, rl, we, re, bsy}), 0);
    check_eq({tag, ".gb_addr"}, 64'(ad), 0);
    check_eq({tag, ".gb_dout"}, 64'(dout), 0);
    check_eq({tag, ".rsp_data"}, 64'(rd), 0);
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b1;
    cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_len = '0;
    ref_reg = 32'h0;
    for (int j = 0; j < 64; j++) ref_ram[j] = 8'(8'h81 + j);

    repeat (3) @(posedge clk);
    #1;
    check_rst("a.rst", a_cmd_ready, a_rsp_valid, a_rsp_last, a_gb_we, a_gb_re, a_busy,
              a_gb_addr, a_gb_dout, a_rsp_data);
    check_rst("b.rst", b_cmd_ready, b_rsp_valid, b_rsp_last, b_gb_we, b_gb_re, b_busy,
              b_gb_addr, b_gb_dout, b_rsp_data);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("a.ready_after_rst", 64'(a_cmd_ready), 1);
    check_eq("b.ready_after_rst", 64'(b_cmd_ready), 1);

    // Register write/readback and RAM reads/writes.
    issue(1'b1, 24'h000000, 32'hDEADBEEF, 0); wait_done();
    issue(1'b0, 24'h000000, 32'h0, 0);        wait_done();
    issue(1'b0, 24'h000105, 32'h0, 0);        wait_done();
    issue(1'b1, 24'h000110, 32'h00000055, 0); wait_done();
    issue(1'b0, 24'h000110, 32'h0, 0);        wait_done();

    // Burst across the end of RAM (single beat when bursts are disabled).
    issue(1'b0, 24'h00013E, 32'h0, 3);        wait_done();

    // Response back-pressure.
    rsp_ready = 1'b0;
    issue(1'b0, 24'h000101, 32'h0, 2);
    for (int t = 0; t < 50 && !(a_rsp_valid && b_rsp_valid); t++) begin
      @(posedge clk); #1;
    end
    check_eq("stall_rsp_seen", 64'({a_rsp_valid, b_rsp_valid}), 64'(2'b11));
    repeat (10) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_done();

    // Address wrap at the top of the 24-bit space.
    issue(1'b1, 24'hFFFFFF, 32'h12345678, 1); wait_done();
    issue(1'b0, 24'hFFFFFF, 32'h0, 1);        wait_done();

    // Reset while a read is waiting for data.
    issue(1'b0, 24'h000107, 32'h0, 0);
    for (int t = 0; t < 20 && !a_gb_re; t++) begin
      @(posedge clk); #1;
    end
    check_eq("rst_test_re_seen", 64'(a_gb_re), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int id = 0; id < 2; id++) begin
      st_q[id].delete();
      rs_q[id].delete();
    end
    @(posedge clk); #1;
    check_rst("a.midrst", a_cmd_ready, a_rsp_valid, a_rsp_last, a_gb_we, a_gb_re, a_busy,
              a_gb_addr, a_gb_dout, a_rsp_data);
    check_rst("b.midrst", b_cmd_ready, b_rsp_valid, b_rsp_last, b_gb_we, b_gb_re, b_busy,
              b_gb_addr, b_gb_dout, b_rsp_data);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("a.midrst_ready", 64'(a_cmd_ready), 1);
    check_eq("b.midrst_ready", 64'(b_cmd_ready), 1);
    check_eq("midrst_no_strobe", 64'({a_gb_we, a_gb_re, b_gb_we, b_gb_re}), 0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("midrst_no_rsp", 64'({a_rsp_valid, b_rsp_valid}), 0);

    // Normal operation resumes after the abandoned read.
    issue(1'b0, 24'h000000, 32'h0, 0);        wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
